acia_rx_ctrl: RTL and testbench

ACIA_RX_CTRL -- requirements
Module: acia_rx_ctrl

---
 rtl/acia_pkg.sv | 31 +++
 rtl/acia_rx_fifo.sv | 58 +++++
 rtl/acia_rx_ctrl.sv | 87 ++++++++
 tb/tb_acia_rx_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/acia_pkg.sv
// Shared definitions for the ACIA receive controller.
// Defining ACIA_RX_FIFO_EN selects a 4-entry receive buffer; otherwise a single holding register.
package acia_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_TAKE     = 2'd1,
      ST_WAIT_CLR = 2'd2
   } rx_state_t;

`ifdef ACIA_RX_FIFO_EN
   localparam int ACIA_RX_DEPTH = 4;
`else
   localparam int ACIA_RX_DEPTH = 1;
`endif

   // Entry layout: {overflow, parity, frame, data[7:0]}
   localparam int ACIA_RX_ENTRY_W = 11;
   typedef logic [ACIA_RX_ENTRY_W-1:0] rx_entry_t;

   localparam int ACIA_RX_PTR_W = (ACIA_RX_DEPTH > 1) ? $clog2(ACIA_RX_DEPTH) : 1;
   localparam int ACIA_RX_CNT_W = $clog2(ACIA_RX_DEPTH + 1);

   function automatic logic [ACIA_RX_PTR_W-1:0] rx_ptr_next(input logic [ACIA_RX_PTR_W-1:0] p);
      if (p == ACIA_RX_PTR_W'(ACIA_RX_DEPTH - 1))
         return '0;
      else
         return p + ACIA_RX_PTR_W'(1);
   endfunction

endpackage

// File: rtl/acia_rx_fifo.sv
// Receive buffer storage: circular buffer with explicit count, depth from acia_pkg.
// When empty, head shows the last popped entry so the CPU view holds steady.
module acia_rx_fifo
   import acia_pkg::*;
(
   input  logic      PHI2,
   input  logic      RESET,
   input  logic      push,
   input  rx_entry_t push_data,
   input  logic      pop,
   output logic      full,
   output logic      empty,
   output rx_entry_t head
);

   rx_entry_t                mem [ACIA_RX_DEPTH];
   logic [ACIA_RX_PTR_W-1:0] wr_ptr;
   logic [ACIA_RX_PTR_W-1:0] rd_ptr;
   logic [ACIA_RX_CNT_W-1:0] cnt;
   rx_entry_t                last_q;
   logic                     do_push;
   logic                     do_pop;

   assign full    = (cnt == ACIA_RX_CNT_W'(ACIA_RX_DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge PHI2 or negedge RESET) begin
      if (!RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         last_q <= '0;
      end else begin
         if (do_push)
            wr_ptr <= rx_ptr_next(wr_ptr);
         if (do_pop) begin
            rd_ptr <= rx_ptr_next(rd_ptr);
            last_q <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + ACIA_RX_CNT_W'(1);
            2'b01:   cnt <= cnt - ACIA_RX_CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: it is never visible while the count is zero.
   always_ff @(posedge PHI2) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

   assign head = empty ? last_q : mem[rd_ptr];

endmodule

// File: rtl/acia_rx_ctrl.sv
// ACIA receive controller: take handshake with the receiver, buffer, CPU read and IRQB.
// Buffer depth is 4 with ACIA_RX_FIFO_EN defined, 1 otherwise.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | waiting for RXFULL_IN with buffer room; byte pushed on exit
// ST_TAKE     | RXTAKEN high for this single cycle
// ST_WAIT_CLR | waiting for receiver to drop RXFULL_IN before next capture
module acia_rx_ctrl
   import acia_pkg::*;
(
   input  logic       PHI2,
   input  logic       RESET,
   input  logic [7:0] RXDATA_IN,
   input  logic       RXFULL_IN,
   input  logic       FRAME_IN,
   input  logic       PARITY_IN,
   input  logic       OVERFLOW_IN,
   input  logic       CS_RD,
   input  logic       IRQ_EN,
   output logic       RXTAKEN,
   output logic [7:0] DOUT,
   output logic       DAV,
   output logic       ERR_FRAME,
   output logic       ERR_PARITY,
   output logic       ERR_OVR,
   output logic       IRQB
);

   rx_state_t state;
   rx_entry_t head;
   logic      fifo_full;
   logic      fifo_empty;
   logic      push;

   // Full is judged on the pre-pop count, so a same-edge read never makes room.
   assign push = (state == ST_IDLE) & RXFULL_IN & ~fifo_full;

   always_ff @(posedge PHI2 or negedge RESET) begin
      if (!RESET) begin
         state   <= ST_IDLE;
         RXTAKEN <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               RXTAKEN <= 1'b0;
               if (push) begin
                  state   <= ST_TAKE;
                  RXTAKEN <= 1'b1;
               end
            end
            ST_TAKE: begin
               RXTAKEN <= 1'b0;
               state   <= ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
               RXTAKEN <= 1'b0;
               if (!RXFULL_IN)
                  state <= ST_IDLE;
            end
            default: begin
               RXTAKEN <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   acia_rx_fifo u_fifo (
      .PHI2      (PHI2),
      .RESET     (RESET),
      .push      (push),
      .push_data ({OVERFLOW_IN, PARITY_IN, FRAME_IN, RXDATA_IN}),
      .pop       (CS_RD),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head)
   );

   assign DOUT       = head[7:0];
   assign ERR_FRAME  = head[8];
   assign ERR_PARITY = head[9];
   assign ERR_OVR    = head[10];
   assign DAV        = ~fifo_empty;
   assign IRQB       = ~(IRQ_EN & DAV);

endmodule

// File: tb/tb_acia_rx_ctrl.sv
// Directed bench for acia_rx_ctrl: vector table plus hand sequences for handshake, fill and reset cases.
module tb_acia_rx_ctrl;
   import acia_pkg::*;

   logic       PHI2 = 1'b0;
   logic       RESET;
   logic [7:0] RXDATA_IN;
   logic       RXFULL_IN, FRAME_IN, PARITY_IN, OVERFLOW_IN, CS_RD, IRQ_EN;
   logic       RXTAKEN, DAV, ERR_FRAME, ERR_PARITY, ERR_OVR, IRQB;
   logic [7:0] DOUT;

   int n_vec = 0;
   int n_bad = 0;
   logic [7:0] exp_q[$];

   always #5 PHI2 = ~PHI2;

   acia_rx_ctrl dut (
      .PHI2(PHI2), .RESET(RESET), .RXDATA_IN(RXDATA_IN), .RXFULL_IN(RXFULL_IN),
      .FRAME_IN(FRAME_IN), .PARITY_IN(PARITY_IN), .OVERFLOW_IN(OVERFLOW_IN),
      .CS_RD(CS_RD), .IRQ_EN(IRQ_EN), .RXTAKEN(RXTAKEN), .DOUT(DOUT), .DAV(DAV),
      .ERR_FRAME(ERR_FRAME), .ERR_PARITY(ERR_PARITY), .ERR_OVR(ERR_OVR), .IRQB(IRQB)
   );

   typedef struct {
      logic       rxfull;
      logic [7:0] data;
      logic [2:0] flg;     // {ovr, parity, frame}
      logic       cs_rd;
      logic       irq_en;
      logic       x_taken;
      logic       x_dav;
      logic [7:0] x_dout;
      logic [2:0] x_err;
      logic       x_irqb;
   } vec_t;

   vec_t vt[15];

   function automatic vec_t mk(logic rf, logic [7:0] d, logic [2:0] f, logic rd, logic ie,
                               logic tk, logic dv, logic [7:0] xd, logic [2:0] xe, logic xi);
      vec_t v;
      v.rxfull = rf; v.data = d; v.flg = f; v.cs_rd = rd; v.irq_en = ie;
      v.x_taken = tk; v.x_dav = dv; v.x_dout = xd; v.x_err = xe; v.x_irqb = xi;
      return v;
   endfunction

   function automatic logic [13:0] pk(logic tk, logic dv, logic [7:0] d, logic [2:0] e, logic ib);
      return {tk, dv, d, e, ib};
   endfunction

   function automatic logic [13:0] obs();
      return {RXTAKEN, DAV, DOUT, ERR_OVR, ERR_PARITY, ERR_FRAME, IRQB};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge PHI2);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] d, output bit taken);
      RXDATA_IN = d; FRAME_IN = 0; PARITY_IN = 0; OVERFLOW_IN = 0; RXFULL_IN = 1;
      taken = 0;
      for (int k = 0; k < 6 && !taken; k++) begin
         tick();
         if (RXTAKEN) taken = 1;
      end
      if (taken) begin
         RXFULL_IN = 0;
         tick();
         tick();
      end
   endtask

   task automatic drain_q();
      while (exp_q.size() != 0) begin
         check("drain_head", {7'd0, DAV, DOUT}, {7'd0, 1'b1, exp_q[0]});
         void'(exp_q.pop_front());
         CS_RD = 1;
         tick();
         CS_RD = 0;
      end
      check("drain_empty", {15'd0, DAV}, 16'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1);
   end

   initial begin
      bit         tk, room;
      int         n;
      logic [7:0] popped, xd;

      vt[0]  = mk(0, 8'h00, 3'b000, 0, 0,  0, 0, 8'h00, 3'b000, 1);
      vt[1]  = mk(1, 8'hA5, 3'b001, 0, 1,  1, 1, 8'hA5, 3'b001, 0);
      vt[2]  = mk(1, 8'hA5, 3'b001, 0, 1,  0, 1, 8'hA5, 3'b001, 0);
      vt[3]  = mk(1, 8'hA5, 3'b001, 0, 1,  0, 1, 8'hA5, 3'b001, 0);
      vt[4]  = mk(0, 8'h00, 3'b000, 0, 1,  0, 1, 8'hA5, 3'b001, 0);
      vt[5]  = mk(0, 8'h00, 3'b000, 1, 1,  0, 0, 8'hA5, 3'b001, 1);
      vt[6]  = mk(0, 8'h00, 3'b000, 1, 1,  0, 0, 8'hA5, 3'b001, 1);
      vt[7]  = mk(1, 8'h3C, 3'b110, 0, 0,  1, 1, 8'h3C, 3'b110, 1);
      vt[8]  = mk(0, 8'h00, 3'b000, 0, 0,  0, 1, 8'h3C, 3'b110, 1);
      vt[9]  = mk(0, 8'h00, 3'b000, 0, 0,  0, 1, 8'h3C, 3'b110, 1);
      vt[10] = mk(0, 8'h00, 3'b000, 0, 1,  0, 1, 8'h3C, 3'b110, 0);
      vt[11] = mk(0, 8'h00, 3'b000, 1, 1,  0, 0, 8'h3C, 3'b110, 1);
      vt[12] = mk(1, 8'h5A, 3'b000, 1, 1,  1, 1, 8'h5A, 3'b000, 0);
      vt[13] = mk(0, 8'h00, 3'b000, 1, 1,  0, 0, 8'h5A, 3'b000, 1);
      vt[14] = mk(0, 8'h00, 3'b000, 0, 1,  0, 0, 8'h5A, 3'b000, 1);

      RESET = 0; RXDATA_IN = 0; RXFULL_IN = 0; FRAME_IN = 0; PARITY_IN = 0;
      OVERFLOW_IN = 0; CS_RD = 0; IRQ_EN = 1;
      #1;
      check("reset_state", {2'd0, obs()}, {2'd0, pk(0, 0, 8'h00, 3'b000, 1)});
      tick();
      tick();
      RESET = 1;

      for (int i = 0; i < 15; i++) begin
         RXFULL_IN = vt[i].rxfull; RXDATA_IN = vt[i].data;
         {OVERFLOW_IN, PARITY_IN, FRAME_IN} = vt[i].flg;
         CS_RD = vt[i].cs_rd; IRQ_EN = vt[i].irq_en;
         tick();
         check($sformatf("vec%0d", i), {2'd0, obs()},
               {2'd0, pk(vt[i].x_taken, vt[i].x_dav, vt[i].x_dout, vt[i].x_err, vt[i].x_irqb)});
      end
      RXFULL_IN = 0; CS_RD = 0; IRQ_EN = 0;
      {OVERFLOW_IN, PARITY_IN, FRAME_IN} = 3'b000;

      // RXFULL held well past the acknowledge: one capture only
      RXDATA_IN = 8'h77; RXFULL_IN = 1;
      n = 0;
      repeat (7) begin
         tick();
         if (RXTAKEN) n++;
      end
      check("hold_one_take", 16'(n), 16'd1);
      RXFULL_IN = 0;
      tick();
      tick();
      check("hold_head", {7'd0, DAV, DOUT}, {7'd0, 1'b1, 8'h77});
      CS_RD = 1;
      tick();
      CS_RD = 0;
      check("hold_single_entry", {15'd0, DAV}, 16'd0);

      // Fill past depth: the extra byte waits until a read makes room
      for (int i = 1; i <= ACIA_RX_DEPTH + 1; i++) begin
         push_byte(8'(i), tk);
         check($sformatf("fill_take%0d", i), {15'd0, tk}, {15'd0, (i <= ACIA_RX_DEPTH)});
      end
      check("fill_head", {7'd0, DAV, DOUT}, {7'd0, 1'b1, 8'h01});
      CS_RD = 1;
      tick();
      CS_RD = 0;
      tk = 0;
      for (int k = 0; k < 4 && !tk; k++) begin
         tick();
         if (RXTAKEN) tk = 1;
      end
      check("pending_take", {15'd0, tk}, 16'd1);
      RXFULL_IN = 0;
      tick();
      tick();
      for (int i = 2; i <= ACIA_RX_DEPTH + 1; i++) exp_q.push_back(8'(i));
      drain_q();

      // Push and read on the same edge
      n = (ACIA_RX_DEPTH >= 2) ? 2 : 1;
      for (int i = 0; i < n; i++) begin
         push_byte(8'(8'h11 * (i + 1)), tk);
         check("pre_take", {15'd0, tk}, 16'd1);
         exp_q.push_back(8'(8'h11 * (i + 1)));
      end
      room = (n < ACIA_RX_DEPTH);
      RXDATA_IN = 8'h33; RXFULL_IN = 1; CS_RD = 1;
      tick();
      CS_RD = 0;
      popped = exp_q.pop_front();
      xd = (exp_q.size() != 0) ? exp_q[0] : popped;
      check("same_edge", {2'd0, obs()},
            {2'd0, pk(room, room | (exp_q.size() != 0), xd, 3'b000, 1'b1)});
      tk = RXTAKEN;
      for (int k = 0; k < 4 && !tk; k++) begin
         tick();
         if (RXTAKEN) tk = 1;
      end
      check("same_edge_take", {15'd0, tk}, 16'd1);
      exp_q.push_back(8'h33);
      RXFULL_IN = 0;
      tick();
      tick();
      drain_q();

      // Reset during WAIT_CLR, then again during TAKE
      IRQ_EN = 1; RXDATA_IN = 8'h99; RXFULL_IN = 1;
      tick();
      tick();
      check("pre_reset_dav", {15'd0, DAV}, 16'd1);
      #2 RESET = 0;
      #1 check("rst_wait_clr", {2'd0, obs()}, {2'd0, pk(0, 0, 8'h00, 3'b000, 1)});
      tick();
      check("rst_hold_no_take", {15'd0, RXTAKEN}, 16'd0);
      RESET = 1;
      tick();
      check("rst_recapture", {2'd0, obs()}, {2'd0, pk(1, 1, 8'h99, 3'b000, 0)});
      #2 RESET = 0;
      #1 check("rst_take", {2'd0, obs()}, {2'd0, pk(0, 0, 8'h00, 3'b000, 1)});
      RXFULL_IN = 0;
      tick();
      RESET = 1;
      tick();
      check("rst_release_idle", {2'd0, obs()}, {2'd0, pk(0, 0, 8'h00, 3'b000, 1)});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
